ext_pipe: RTL and testbench
===========================

# ext_pipe

Pipelined, parametrised operand/load-data extension unit for the MIPS datapath. It accepts an extension request on a valid/ready handshake and produces a DATA_W-wide result one cycle later. It covers immediate extension (SE/ZE/LS) and sub-word load alignment and extension (LB/LBU/LH/LHU) with a misalignment flag. A 2-entry output buffer absorbs downstream stalls without losing a beat. It sits between the MEM stage (load data return) and decode (immediate path), and is shared by both through the tag sideband.

## Interface
- DATA_W, 32: result and source width; legal values are 32 and 64.
- IMM_W, 16: immediate width; must be less than or equal to DATA_W/2.
- LS_SHIFT, 16: left-shift applied by the LS op.
- TAG_W, 4: opaque sideband width, returned unchanged with the result.

- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  3  extension op; codes are defined in the shared package.
- in_src  in  DATA_W  source; immediate ops use in_src[IMM_W-1:0].
- in_off  in  OFF_W = $clog2(DATA_W/8)  byte offset, used by load ops only.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  extended result.
- out_err  out  1  misaligned halfword request; out_data is 0 when set.
- out_tag  out  TAG_W  sideband of the result.

## Operation
- Op codes:
  - SE=0: sign-extend imm.
  - ZE=1: zero-extend imm.
  - LS=2: (imm << LS_SHIFT), sign-extended from bit IMM_W+LS_SHIFT-1 to DATA_W.
  - LB=3: sign-extend byte lane in_off.
  - LBU=4: zero-extend byte lane in_off.
  - LH=5: sign-extend halfword starting at lane in_off.
  - LHU=6: zero-extend halfword starting at lane in_off.
  - PASS=7: in_src unchanged.
- Byte lanes are little-endian: lane k = in_src[8k+7:8k].
- Misalignment: LH/LHU with in_off[0]=1 sets out_err=1 and forces out_data=0. All other ops set out_err=0 regardless of in_off.
- Immediate ops ignore in_off and in_src[DATA_W-1:IMM_W].
- Buffer:
  - 2-entry FIFO holding {data, err, tag}, with count register cnt ∈ {0,1,2}.
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- in_ready = (cnt != 2). It depends on registered state only, with no combinational path from out_ready.
- out_valid = (cnt != 0). out_data/out_err/out_tag always show the head entry.
- Simultaneous push and pop:
  - cnt=1: cnt stays 1 and the new entry becomes head next cycle.
  - cnt=2: no push is possible, so only the pop occurs.
- FIFO order is preserved; no entry is dropped or duplicated.
- flush: cnt <= 0 next cycle. A push in the same cycle is discarded. flush has priority over push and pop.
- Reset (rst_n=0 at edge), regardless of in-flight traffic:
  - cnt=0, out_valid=0, in_ready=1.
  - out_data=0, out_err=0, out_tag=0, storage cleared.
- An unknown op cannot occur because the 3-bit space is fully decoded.

## Timing
- Latency: a request accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1) if the buffer was empty.
- Throughput: 1 result per cycle while out_ready=1.
- With out_ready=0, two requests are absorbed and in_ready drops the cycle after the second acceptance.
- When out_ready is released, in_ready rises the cycle after the first pop.
- Extension logic is purely combinational before the buffer write. Critical path: lane mux plus sign replicate.

## Structure
- Shared package (common.v): the EXT_OP_* codes SE, ZE, LS, LB, LBU, LH, LHU, PASS as 3-bit defines. Existing SE/ZE/LS codes keep their values 0/1/2.
- Sub-module ext_func: combinational {op, src, off} -> {data, err}, parametrised by DATA_W, IMM_W and LS_SHIFT. ext_pipe instantiates it and adds the 2-entry buffer and handshake.

## Test plan
- Immediate ops, DATA_W=32, out_ready=1:
  - SE with src=0x0000_8001 -> 0xFFFF_8001.
  - ZE -> 0x0000_8001.
  - LS with imm=0x1234 -> 0x1234_0000, with out_valid exactly one cycle after acceptance.
- Loads, src=0x80FF_7F01:
  - LB off=1 -> 0x0000_007F.
  - LB off=2 -> 0xFFFF_FFFF.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LH off=1 -> out_err=1, out_data=0.
- Backpressure: hold out_ready=0 and push tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready=0 on the 3rd attempt.
  - Release out_ready: outputs appear in order 1, 2, then 3.
- Simultaneous push and pop at cnt=1 for 10 back-to-back cycles: no bubble, no loss, order preserved.
- flush with cnt=2 and in_valid=1 in the same cycle: next cycle out_valid=0 and in_ready=1, and the flushed-cycle request never appears.
- Reset mid-stream (rst_n=0 for 1 cycle with cnt=2): all outputs 0, in_ready=1, and operation resumes normally. Repeat with DATA_W=64: LS with imm=0x8000 -> 0xFFFF_FFFF_8000_0000.

Source files
------------

// File: rtl/ext_pipe_pkg.sv
// Shared definitions for the extension unit.
// Holds the 3-bit extension op codes and small decode helpers used by
// the datapath and the buffer.
package ext_pipe_pkg;

   localparam int unsigned EXT_OP_W = 3;

   // SE/ZE/LS keep their historical codes 0/1/2
   typedef enum logic [EXT_OP_W-1:0] {
      EXT_OP_SE   = 3'd0,
      EXT_OP_ZE   = 3'd1,
      EXT_OP_LS   = 3'd2,
      EXT_OP_LB   = 3'd3,
      EXT_OP_LBU  = 3'd4,
      EXT_OP_LH   = 3'd5,
      EXT_OP_LHU  = 3'd6,
      EXT_OP_PASS = 3'd7
   } ext_op_e;

   // Halfword loads are the only ops with an alignment constraint
   function automatic logic op_is_half(ext_op_e op);
      return (op == EXT_OP_LH) || (op == EXT_OP_LHU);
   endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Request/result handshake bundle for ext_pipe.
// slave : the extension unit (consumes in_*, produces out_*)
// master: the requester/consumer side
// flush travels with the bundle because it belongs to the same pipeline.
interface ext_pipe_if
   import ext_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
);
   localparam int unsigned OFF_W = $clog2(DATA_W / 8);

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   ext_op_e           in_op;
   logic [DATA_W-1:0] in_src;
   logic [OFF_W-1:0]  in_off;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;
   logic [TAG_W-1:0]  out_tag;

   modport slave (
      input  flush, in_valid, in_op, in_src, in_off, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_err, out_tag
   );

   modport master (
      output flush, in_valid, in_op, in_src, in_off, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_err, out_tag
   );

endinterface

// File: rtl/ext_pipe_func.sv
// ext_func: combinational operand/load-data extension.
// Ports: op_i (ext op), src_i (source word), off_i (byte offset for loads)
//        -> data_o (extended result), err_o (misaligned halfword).
module ext_func
   import ext_pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned LS_SHIFT = 16,
   parameter int unsigned OFF_W    = $clog2(DATA_W / 8)
) (
   input  ext_op_e           op_i,
   input  logic [DATA_W-1:0] src_i,
   input  logic [OFF_W-1:0]  off_i,
   output logic [DATA_W-1:0] data_o,
   output logic              err_o
);

   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] imm_sx;
   logic [15:0]       lane_half;
   logic [7:0]        lane_byte;

   // Sign-extending first then shifting makes LS replicate bit IMM_W+LS_SHIFT-1
   always_comb begin
      imm       = src_i[IMM_W-1:0];
      imm_sx    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      lane_half = 16'(src_i >> {off_i, 3'b000});
      lane_byte = lane_half[7:0];
      data_o    = '0;
      err_o     = 1'b0;
      case (op_i)
         EXT_OP_SE:   data_o = imm_sx;
         EXT_OP_ZE:   data_o = DATA_W'(imm);
         EXT_OP_LS:   data_o = imm_sx << LS_SHIFT;
         EXT_OP_LB:   data_o = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
         EXT_OP_LBU:  data_o = DATA_W'(lane_byte);
         EXT_OP_LH:   data_o = {{(DATA_W-16){lane_half[15]}}, lane_half};
         EXT_OP_LHU:  data_o = DATA_W'(lane_half);
         EXT_OP_PASS: data_o = src_i;
         default:     data_o = '0;
      endcase
      // Odd halfword offset: flag it and squash the data
      if (op_is_half(op_i) && off_i[0]) begin
         data_o = '0;
         err_o  = 1'b1;
      end
   end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: extension unit with a 2-entry output buffer.
// Ports: clk, rst_n (sync active-low), bus (ext_pipe_if.slave: flush,
//        in_valid/in_ready/in_op/in_src/in_off/in_tag,
//        out_valid/out_ready/out_data/out_err/out_tag).
// Head entry drives out_*; in_ready/out_valid come straight from flops.
module ext_pipe
   import ext_pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned LS_SHIFT = 16,
   parameter int unsigned TAG_W    = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   ext_pipe_if.slave bus
);

   localparam int unsigned OFF_W = $clog2(DATA_W / 8);
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   logic [DATA_W-1:0] func_data_c;
   logic              func_err_c;
   entry_t            new_ent;
   entry_t            ent_q [2];
   entry_t            ent_d [2];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              push_c, pop_c;

   ext_func #(
      .DATA_W   (DATA_W),
      .IMM_W    (IMM_W),
      .LS_SHIFT (LS_SHIFT),
      .OFF_W    (OFF_W)
   ) u_func (
      .op_i   (bus.in_op),
      .src_i  (bus.in_src),
      .off_i  (bus.in_off),
      .data_o (func_data_c),
      .err_o  (func_err_c)
   );

   // Buffer next-state: flush wins, then pop/push bookkeeping
   always_comb begin
      cnt_d        = cnt_q;
      ent_d        = ent_q;
      new_ent.data = func_data_c;
      new_ent.err  = func_err_c;
      new_ent.tag  = bus.in_tag;
      push_c       = bus.in_valid && in_ready_q;
      pop_c        = out_valid_q && bus.out_ready;

      if (bus.flush) begin
         cnt_d = '0;
      end else if (push_c && pop_c) begin
         // only reachable with one entry: the new one becomes head
         ent_d[0] = new_ent;
      end else if (pop_c) begin
         ent_d[0] = ent_q[1];
         cnt_d    = cnt_q - CNT_W'(1);
      end else if (push_c) begin
         if (cnt_q == '0) ent_d[0] = new_ent;
         else             ent_d[1] = new_ent;
         cnt_d = cnt_q + CNT_W'(1);
      end

      out_valid_d = (cnt_d != '0);
      in_ready_d  = (cnt_d != CNT_W'(2));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         ent_q[0]    <= '0;
         ent_q[1]    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         ent_q       <= ent_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = ent_q[0].data;
   assign bus.out_err   = ent_q[0].err;
   assign bus.out_tag   = ent_q[0].tag;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: a 32-bit and a 64-bit instance share one set of
// handshake stimulus so their buffer behaviour is identical; data is
// checked per width against a spec-level model.
module tb_ext_pipe;
   import ext_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [2:0]  in_op;
   logic [63:0] in_src;
   logic [2:0]  in_off;
   logic [3:0]  in_tag;
   int          total, bad;

   always #5 clk = ~clk;

   ext_pipe_if #(.DATA_W(32), .TAG_W(4)) b32 ();
   ext_pipe_if #(.DATA_W(64), .TAG_W(4)) b64 ();

   assign b32.flush     = flush;
   assign b32.in_valid  = in_valid;
   assign b32.in_op     = ext_op_e'(in_op);
   assign b32.in_src    = in_src[31:0];
   assign b32.in_off    = in_off[1:0];
   assign b32.in_tag    = in_tag;
   assign b32.out_ready = out_ready;
   assign b64.flush     = flush;
   assign b64.in_valid  = in_valid;
   assign b64.in_op     = ext_op_e'(in_op);
   assign b64.in_src    = in_src;
   assign b64.in_off    = in_off;
   assign b64.in_tag    = in_tag;
   assign b64.out_ready = out_ready;

   ext_pipe #(.DATA_W(32), .IMM_W(16), .LS_SHIFT(16), .TAG_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32));
   ext_pipe #(.DATA_W(64), .IMM_W(16), .LS_SHIFT(16), .TAG_W(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .bus(b64));

   typedef struct {
      logic [2:0]  op;
      logic [63:0] src;
      logic [2:0]  off;
      logic [3:0]  tag;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   typedef struct {
      logic [63:0] d;
      logic        e;
      logic [3:0]  t;
   } rec_t;

   vec_t tbl [10];
   rec_t q32 [$];
   rec_t q64 [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Extension computed with integer arithmetic from the op definitions
   function automatic rec_t model(input int dw, input logic [2:0] op,
                                  input logic [63:0] src, input logic [2:0] off,
                                  input logic [3:0] tag);
      rec_t        r;
      longint      imm, simm, b, sb, h, sh, res;
      int          o;
      logic [63:0] mask;
      o    = (dw == 32) ? int'(off) % 4 : int'(off);
      mask = (dw == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      imm  = longint'(src % 65536);
      simm = (imm >= 32768) ? imm - 65536 : imm;
      b    = longint'((src >> (8 * o)) % 256);
      sb   = (b >= 128) ? b - 256 : b;
      h    = longint'((src >> (8 * o)) % 65536);
      sh   = (h >= 32768) ? h - 65536 : h;
      r.e  = 1'b0;
      case (op)
         3'd0: res = simm;
         3'd1: res = imm;
         3'd2: res = simm * 65536;
         3'd3: res = sb;
         3'd4: res = b;
         3'd5: res = sh;
         3'd6: res = h;
         default: res = longint'(src);
      endcase
      if ((op == 3'd5 || op == 3'd6) && (o % 2 == 1)) begin
         r.e = 1'b1;
         res = 0;
      end
      r.d = 64'(res) & mask;
      r.t = tag;
      return r;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [63:0] src,
                        input logic [2:0] off, input logic [3:0] tag);
      in_op = op; in_src = src; in_off = off; in_tag = tag;
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(3'd0, 64'h0, 3'd0, 4'h0);

      tbl[0] = '{3'd0, 64'h0000_8001, 3'd0, 4'h1, 32'hFFFF_8001, 1'b0};
      tbl[1] = '{3'd1, 64'h0000_8001, 3'd2, 4'h2, 32'h0000_8001, 1'b0};
      tbl[2] = '{3'd2, 64'hABCD_1234, 3'd1, 4'h3, 32'h1234_0000, 1'b0};
      tbl[3] = '{3'd3, 64'h80FF_7F01, 3'd1, 4'h4, 32'h0000_007F, 1'b0};
      tbl[4] = '{3'd3, 64'h80FF_7F01, 3'd2, 4'h5, 32'hFFFF_FFFF, 1'b0};
      tbl[5] = '{3'd4, 64'h80FF_7F01, 3'd3, 4'h6, 32'h0000_0080, 1'b0};
      tbl[6] = '{3'd5, 64'h80FF_7F01, 3'd2, 4'h7, 32'hFFFF_80FF, 1'b0};
      tbl[7] = '{3'd6, 64'h80FF_7F01, 3'd0, 4'h8, 32'h0000_7F01, 1'b0};
      tbl[8] = '{3'd5, 64'h80FF_7F01, 3'd1, 4'h9, 32'h0000_0000, 1'b1};
      tbl[9] = '{3'd7, 64'h80FF_7F01, 3'd3, 4'hA, 32'h80FF_7F01, 1'b0};

      // reset state
      step(); step();
      chk("rst_valid", 64'(b32.out_valid), 64'd0);
      chk("rst_ready", 64'(b32.in_ready), 64'd1);
      chk("rst_data", 64'(b32.out_data), 64'd0);
      chk("rst_err", 64'(b32.out_err), 64'd0);
      chk("rst_tag", 64'(b32.out_tag), 64'd0);
      chk("rst_data64", b64.out_data, 64'd0);
      rst_n = 1'b1;
      step();

      // table vectors, one request per cycle with out_ready=1
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].src, tbl[i].off, tbl[i].tag);
         in_valid = 1'b1;
         step();
         chk($sformatf("vec%0d_valid", i), 64'(b32.out_valid), 64'd1);
         chk($sformatf("vec%0d_data", i), 64'(b32.out_data), 64'(tbl[i].exp_d));
         chk($sformatf("vec%0d_err", i), 64'(b32.out_err), 64'(tbl[i].exp_e));
         chk($sformatf("vec%0d_tag", i), 64'(b32.out_tag), 64'(tbl[i].tag));
         in_valid = 1'b0;
      end
      step();
      chk("drain_valid", 64'(b32.out_valid), 64'd0);

      // single-cycle latency from empty, and LS on both widths
      drive(3'd2, 64'h8000, 3'd0, 4'h2);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ls_lat_valid", 64'(b32.out_valid), 64'd1);
      chk("ls32_data", 64'(b32.out_data), 64'h0000_0000_8000_0000);
      chk("ls64_data", b64.out_data, 64'hFFFF_FFFF_8000_0000);
      step();
      chk("ls_popped", 64'(b32.out_valid), 64'd0);

      // backpressure: two absorbed, third refused, release drains in order
      out_ready = 1'b0;
      drive(3'd7, 64'h100, 3'd0, 4'd1);
      in_valid = 1'b1;
      chk("bp_rdy1", 64'(b32.in_ready), 64'd1);
      step();
      in_tag = 4'd2;
      chk("bp_rdy2", 64'(b32.in_ready), 64'd1);
      step();
      in_tag = 4'd3;
      chk("bp_rdy3", 64'(b32.in_ready), 64'd0);
      step();
      chk("bp_hold_rdy", 64'(b32.in_ready), 64'd0);
      chk("bp_head1", 64'(b32.out_tag), 64'd1);
      out_ready = 1'b1;
      step();
      chk("bp_head2", 64'(b32.out_tag), 64'd2);
      chk("bp_rdy_back", 64'(b32.in_ready), 64'd1);
      step();
      chk("bp_head3", 64'(b32.out_tag), 64'd3);
      in_valid = 1'b0;
      step();
      chk("bp_empty", 64'(b32.out_valid), 64'd0);

      // back-to-back push+pop at one entry
      in_valid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_tag = 4'(i);
         step();
         chk($sformatf("b2b%0d_valid", i), 64'(b32.out_valid), 64'd1);
         chk($sformatf("b2b%0d_tag", i), 64'(b32.out_tag), 64'(i));
      end
      in_valid = 1'b0;
      step();
      chk("b2b_empty", 64'(b32.out_valid), 64'd0);

      // flush with full buffer and a request pending, then flush vs push at empty
      out_ready = 1'b0; in_valid = 1'b1;
      in_tag = 4'd5; step();
      in_tag = 4'd6; step();
      flush = 1'b1; in_tag = 4'hE; step();
      chk("fl_valid", 64'(b32.out_valid), 64'd0);
      chk("fl_ready", 64'(b32.in_ready), 64'd1);
      in_tag = 4'hD; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_push_drop", 64'(b32.out_valid), 64'd0);
      step();
      chk("fl_still_empty", 64'(b32.out_valid), 64'd0);
      out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'd7;
      step();
      in_valid = 1'b0;
      chk("fl_resume_tag", 64'(b32.out_tag), 64'd7);
      step();

      // reset mid-stream with a full buffer
      out_ready = 1'b0; in_valid = 1'b1;
      drive(3'd5, 64'h0000_0000_DEAD_BEEF, 3'd1, 4'd9);
      step(); step();
      rst_n = 1'b0; step();
      rst_n = 1'b1; in_valid = 1'b0;
      chk("mrst_valid", 64'(b32.out_valid), 64'd0);
      chk("mrst_ready", 64'(b32.in_ready), 64'd1);
      chk("mrst_data", 64'(b32.out_data), 64'd0);
      chk("mrst_err", 64'(b32.out_err), 64'd0);
      chk("mrst_tag", 64'(b32.out_tag), 64'd0);
      chk("mrst_data64", b64.out_data, 64'd0);
      out_ready = 1'b1; in_valid = 1'b1;
      drive(3'd3, 64'h80FF_7F01, 3'd2, 4'd3);
      step();
      in_valid = 1'b0;
      chk("mrst_resume_data", 64'(b32.out_data), 64'hFFFF_FFFF);
      chk("mrst_resume_tag", 64'(b32.out_tag), 64'd3);
      step();

      // randomized traffic against the queue model (buffer is empty here)
      for (int c = 0; c < 3000; c++) begin
         logic push, pop;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 59) == 0);
         drive(3'($urandom), {$urandom, $urandom}, 3'($urandom), 4'($urandom));
         chk("rnd_valid", 64'(b32.out_valid), 64'(q32.size() != 0));
         chk("rnd_ready", 64'(b32.in_ready), 64'(q32.size() != 2));
         chk("rnd_valid64", 64'(b64.out_valid), 64'(q64.size() != 0));
         pop  = out_ready && (q32.size() != 0);
         push = in_valid && (q32.size() != 2);
         if (pop) begin
            chk("rnd_data32", 64'(b32.out_data), q32[0].d);
            chk("rnd_err32", 64'(b32.out_err), 64'(q32[0].e));
            chk("rnd_tag32", 64'(b32.out_tag), 64'(q32[0].t));
            chk("rnd_data64", b64.out_data, q64[0].d);
            chk("rnd_err64", 64'(b64.out_err), 64'(q64[0].e));
         end
         step();
         if (flush) begin
            q32.delete();
            q64.delete();
         end else begin
            if (pop) begin
               void'(q32.pop_front());
               void'(q64.pop_front());
            end
            if (push) begin
               q32.push_back(model(32, in_op, in_src, in_off, in_tag));
               q64.push_back(model(64, in_op, in_src, in_off, in_tag));
            end
         end
      end
      in_valid = 1'b0; flush = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
